karatsuba_lower_seq: RTL
========================

// Module: karatsuba_lower_seq
// PURPOSE
//  Sequential low-half Karatsuba multiplier: q = (A*B) mod 2^N. It is the
//  companion of the upper-half (q = A*B >> p) product in Barrett modular
//  multiplication, and supplies the low word for r = x - qhat*M mod 2^N.
//  Splits operands into 4 limbs of m = N/4 bits. Time-shares ONE booth
//  multiplier over an 8-step schedule. Valid/ready handshake on both sides.
// PARAMETERS
//  N   64    operand/result width; must be divisible by 4 (limb count k=4, fixed)
//  m   N/4   limb width; derived, not overridable
// PORTS
//  clk        in   1   single clock, rising edge
//  rst_n      in   1   asynchronous, active-low reset
//  in_valid   in   1   A/B present
//  in_ready   out  1   block can accept operands
//  A          in   N   multiplicand, unsigned
//  B          in   N   multiplier, unsigned
//  out_valid  out  1   q holds a finished result
//  out_ready  in   1   consumer accepts q
//  q          out  N   (A*B) mod 2^N
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, step=0, acc=0, q=0, out_valid=0, in_ready=1.
//  Reset mid-operation aborts the job, with no partial output.
//  States: IDLE -> MUL -> DONE -> IDLE.
//  - IDLE: in_ready=1. On in_valid&&in_ready, latch limbs Ai,Bi (i=0..3),
//    acc<=0, step<=0, go MUL. A/B are ignored after the accept edge.
//  - MUL: in_ready=0. Each cycle, booth (m+2 x m+2 -> 2m+4, unsigned,
//    zero-extended) computes product P for the current step. acc is updated
//    mod 2^N. step increments each cycle. After step 7, q<=acc_next,
//    out_valid<=1, go DONE.
//  - DONE: out_valid=1, q stable. On out_ready, go IDLE and drop out_valid.
//    in_ready stays low in DONE, so there is one bubble between jobs.
//  Schedule (W(x) = x<<(m*s), all terms truncated to N bits, sub = 2's-comp wrap):
//    step0 D0=A0*B0: +W0 -W1 -W2 -W3
//    step1 D1=A1*B1: +W2 -W1 -W3
//    step2 D2=A2*B2: -W2 -W3
//    step3 D3=A3*B3: -W3
//    step4 (A0+A1)(B0+B1): +W1
//    step5 (A0+A2)(B0+B2): +W2
//    step6 (A0+A3)(B0+B3): +W3
//    step7 (A1+A2)(B1+B2): +W3
//  Net result = sum_{i+j<4} Ai*Bj*2^(m(i+j)) mod 2^N, which equals A*B mod 2^N.
//  Limb sums are m+1 bits wide. Product width is 2m+4, and terms beyond bit N-1
//  are discarded. Shifted terms at W3 keep only their low m bits, which is
//  legal and intended.
//  Latency: out_valid is first seen high 8 cycles after the accept edge.
//  Throughput: 1 result per 10 cycles with out_ready held high.
//  in_valid while busy: ignored (in_ready=0). No job is lost or overwritten.
//  out_ready while out_valid=0: no effect.
//  q changes only on the MUL->DONE edge and on reset.
// STRUCTURE
//  Shared package kbmm_pkg:
//  - LIMBS=4
//  - step encoding (3-bit)
//  - per-step operand-select table (a-index, b-index, is_sum)
//  - per-step coefficient masks (+/- per W0..W3)
//  - state enum {IDLE,MUL,DONE}
//  Sub-module: the existing booth multiplier, instantiated once with
//  #(m+2, 2m+4). Operand mux, accumulator and FSM are local.
// TESTING
//  1 A=3, B=5 -> q=0x...0F (15). out_valid is high exactly 8 cycles after accept.
//  2 A=B=0xFFFF_FFFF_FFFF_FFFF -> q=0x0000_0000_0000_0001. This exercises wrap
//    on every step.
//  3 A=0x0000_0001_0000_0000, B=0x0000_0001_0000_0000 -> q=0.
//    A=0xFFFF_FFFF_FFFF_FFFF, B=2 -> q=0xFFFF_FFFF_FFFF_FFFE.
//  4 Backpressure: hold out_ready=0 for 5 cycles in DONE, toggle in_valid.
//    Expect: q and out_valid stable, in_ready=0, no second job accepted.
//  5 Reset mid-MUL: assert rst_n=0 at step 3. Expect: immediately out_valid=0,
//    q=0, in_ready=1. Next job A=7, B=9 -> q=63.
//  6 1000 random A/B with random out_ready stalls -> q == (A*B)[N-1:0].
//    Also check {upper-half result, q} consistency against the full golden product.

Source files
------------

// File: rtl/kbmm_pkg.sv
// kbmm_pkg: shared types and per-step schedule tables for the low-half Karatsuba multiplier
package kbmm_pkg;
  localparam int LIMBS = 4;
  typedef logic [2:0] step_t;
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_e;
  // Operand select: limb i0, plus limb i1 when is_sum (same indices on A and B)
  typedef struct packed {
    logic [1:0] i0;
    logic [1:0] i1;
    logic       is_sum;
  } sel_t;
  localparam sel_t SEL [8] = '{
    '{2'd0, 2'd0, 1'b0}, '{2'd1, 2'd1, 1'b0}, '{2'd2, 2'd2, 1'b0}, '{2'd3, 2'd3, 1'b0},
    '{2'd0, 2'd1, 1'b1}, '{2'd0, 2'd2, 1'b1}, '{2'd0, 2'd3, 1'b1}, '{2'd1, 2'd2, 1'b1}
  };
  // Bit s set: add (POS) or subtract (NEG) the step product shifted by m*s
  localparam logic [3:0] POS [8] = '{4'b0001, 4'b0100, 4'b0000, 4'b0000,
                                     4'b0010, 4'b0100, 4'b1000, 4'b1000};
  localparam logic [3:0] NEG [8] = '{4'b1110, 4'b1010, 4'b1100, 4'b1000,
                                     4'b0000, 4'b0000, 4'b0000, 4'b0000};
endpackage

// File: rtl/karatsuba_lower_seq_booth.sv
// karatsuba_lower_seq_booth: combinational radix-4 Booth multiplier, unsigned W x W -> PW
// ports: a, b (W, unsigned) in; p (PW) out = a*b mod 2^PW
module karatsuba_lower_seq_booth #(
  parameter int W  = 18,
  parameter int PW = 36
) (
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  output logic [PW-1:0] p
);
  // Enough groups to cover b plus one zero sign bit, so b is always read as unsigned
  localparam int G = (W + 2) / 2;
  logic [W+2:0]  bx;
  logic [PW-1:0] ax, mag, pp;
  logic [2:0]    t;
  assign bx = {2'b00, b, 1'b0};
  assign ax = {{(PW-W){1'b0}}, a};
  always_comb begin
    p = '0;
    t = '0;
    mag = '0;
    pp = '0;
    for (int i = 0; i < G; i++) begin
      t = bx[2*i +: 3];
      mag = (t == 3'b011 || t == 3'b100) ? ax << 1 : (t == 3'b000 || t == 3'b111) ? '0 : ax;
      pp = t[2] ? -mag : mag;
      p = p + (pp << (2*i));
    end
  end
endmodule

// File: rtl/karatsuba_lower_seq.sv
// karatsuba_lower_seq: sequential low-half Karatsuba multiplier, q = (A*B) mod 2^N over 8 booth steps
// ports: clk, rst_n (async low); in_valid/in_ready/A/B operand side; out_valid/out_ready/q result side
module karatsuba_lower_seq
  import kbmm_pkg::*;
#(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] q
);
  localparam int m = N / LIMBS;
  state_e         state_q, state_d;
  step_t          step_q, step_d;
  logic [N-1:0]   a_q, a_d, b_q, b_d, acc_q, acc_d, acc_nxt, q_q, q_d, p_n;
  logic [m+1:0]   op_a, op_b;
  logic [2*m+3:0] p;
  sel_t           sel;
  karatsuba_lower_seq_booth #(.W(m + 2), .PW(2*m + 4)) u_booth (.a(op_a), .b(op_b), .p(p));
  always_comb begin
    sel = SEL[step_q];
    op_a = {2'b00, a_q[m*sel.i0 +: m]} + (sel.is_sum ? {2'b00, a_q[m*sel.i1 +: m]} : '0);
    op_b = {2'b00, b_q[m*sel.i0 +: m]} + (sel.is_sum ? {2'b00, b_q[m*sel.i1 +: m]} : '0);
  end
  // Terms above bit N-1 fall off here; that truncation is what makes the low half exact
  assign p_n = N'(p);
  always_comb begin
    acc_nxt = acc_q;
    for (int s = 0; s < LIMBS; s++)
      acc_nxt = acc_nxt + (POS[step_q][s] ? p_n << (m*s) : '0) - (NEG[step_q][s] ? p_n << (m*s) : '0);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  always_comb
    state_d = (state_q == IDLE && in_valid) ? MUL :
              (state_q == MUL && step_q == 3'd7) ? DONE :
              (state_q == DONE && out_ready) ? IDLE : state_q;
  always_comb begin
    a_d = (state_q == IDLE && in_valid) ? A : a_q;
    b_d = (state_q == IDLE && in_valid) ? B : b_q;
    acc_d = (state_q == IDLE && in_valid) ? '0 : (state_q == MUL) ? acc_nxt : acc_q;
    step_d = (state_q == IDLE && in_valid) ? '0 : (state_q == MUL) ? step_q + 3'd1 : step_q;
    q_d = (state_q == MUL && step_q == 3'd7) ? acc_nxt : q_q;
  end
  always_comb begin
    in_ready = state_q == IDLE;
    out_valid = state_q == DONE;
    q = q_q;
  end
endmodule
